// File: rtl/deconcatenator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | deconcatenator: splits a framed byte stream into a byte segment and two   |
// | 96-bit word segments.                                  Revision: 1.0     |
// +--------------------------------------------------------------------------+
module deconcatenator #(
  parameter int FIRST_BYTES  = 144,
  parameter int SECOND_WORDS = 1,
  parameter int THIRD_WORDS  = 11
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [7:0]  i_in_data,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  output logic [7:0]  o_first_data,
  output logic        o_first_valid,
  input  logic        i_first_ready,
  output logic [95:0] o_second_data,
  output logic        o_second_valid,
  input  logic        i_second_ready,
  output logic [95:0] o_third_data,
  output logic        o_third_valid,
  input  logic        i_third_ready
);

  localparam int c_BYTE_MAX = (FIRST_BYTES > 12) ? FIRST_BYTES : 12;
  localparam int c_WORD_MAX = (SECOND_WORDS > THIRD_WORDS) ? SECOND_WORDS : THIRD_WORDS;
  localparam int c_BYTE_W   = $clog2(c_BYTE_MAX);
  localparam int c_WORD_W   = (c_WORD_MAX > 1) ? $clog2(c_WORD_MAX) : 1;
  localparam int c_ASM_W    = 88;

  localparam logic [c_BYTE_W-1:0] c_FIRST_LAST  = c_BYTE_W'(FIRST_BYTES - 1);
  localparam logic [c_BYTE_W-1:0] c_LANE_LAST   = c_BYTE_W'(11);
  localparam logic [c_WORD_W-1:0] c_SECOND_LAST = c_WORD_W'(SECOND_WORDS - 1);
  localparam logic [c_WORD_W-1:0] c_THIRD_LAST  = c_WORD_W'(THIRD_WORDS - 1);

  typedef enum logic [1:0] {
    ST_FIRST  = 2'd0,
    ST_SECOND = 2'd1,
    ST_THIRD  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [c_BYTE_W-1:0]   r_byte_cnt;
  logic [c_BYTE_W-1:0]   w_byte_cnt_next;
  logic [c_WORD_W-1:0]   r_word_cnt;
  logic [c_WORD_W-1:0]   w_word_cnt_next;
  logic [c_ASM_W-1:0]    r_asm;
  logic [7:0]            r_first_data;
  logic                  r_first_valid;
  logic [95:0]           r_second_data;
  logic                  r_second_valid;
  logic [95:0]           r_third_data;
  logic                  r_third_valid;

  logic w_in_ready;
  logic w_lane_last;
  logic w_assemble;
  logic w_load_first;
  logic w_load_second;
  logic w_load_third;

  assign w_lane_last = (r_byte_cnt == c_LANE_LAST);

  // Next-state, counters and handshake decode
  always_comb begin
    w_state_next    = r_state;
    w_byte_cnt_next = r_byte_cnt;
    w_word_cnt_next = r_word_cnt;
    w_in_ready      = 1'b0;
    w_assemble      = 1'b0;
    w_load_first    = 1'b0;
    w_load_second   = 1'b0;
    w_load_third    = 1'b0;
    case (r_state)
      ST_FIRST: begin
        w_in_ready = !r_first_valid || i_first_ready;
        if (i_in_valid && w_in_ready) begin
          w_load_first = 1'b1;
          if (r_byte_cnt == c_FIRST_LAST) begin
            w_byte_cnt_next = '0;
            w_state_next    = ST_SECOND;
          end else begin
            w_byte_cnt_next = r_byte_cnt + 1'b1;
          end
        end
      end
      ST_SECOND: begin
        w_in_ready = !w_lane_last || !r_second_valid || i_second_ready;
        if (i_in_valid && w_in_ready) begin
          if (w_lane_last) begin
            w_load_second   = 1'b1;
            w_byte_cnt_next = '0;
            if (r_word_cnt == c_SECOND_LAST) begin
              w_word_cnt_next = '0;
              w_state_next    = ST_THIRD;
            end else begin
              w_word_cnt_next = r_word_cnt + 1'b1;
            end
          end else begin
            w_assemble      = 1'b1;
            w_byte_cnt_next = r_byte_cnt + 1'b1;
          end
        end
      end
      ST_THIRD: begin
        w_in_ready = !w_lane_last || !r_third_valid || i_third_ready;
        if (i_in_valid && w_in_ready) begin
          if (w_lane_last) begin
            w_load_third    = 1'b1;
            w_byte_cnt_next = '0;
            if (r_word_cnt == c_THIRD_LAST) begin
              w_word_cnt_next = '0;
              w_state_next    = ST_FIRST;
            end else begin
              w_word_cnt_next = r_word_cnt + 1'b1;
            end
          end else begin
            w_assemble      = 1'b1;
            w_byte_cnt_next = r_byte_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next    = ST_FIRST;
        w_byte_cnt_next = '0;
        w_word_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= ST_FIRST;
      r_byte_cnt <= '0;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_byte_cnt <= w_byte_cnt_next;
      r_word_cnt <= w_word_cnt_next;
    end
  end

  // Lanes 0..10 are staged here; lane 11 goes straight into the output word
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_asm <= '0;
    end else if (w_assemble) begin
      for (int k = 0; k < 11; k++) begin
        if (r_byte_cnt == c_BYTE_W'(k)) begin
          r_asm[8*k +: 8] <= i_in_data;
        end
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_first_data  <= '0;
      r_first_valid <= 1'b0;
    end else if (w_load_first) begin
      r_first_data  <= i_in_data;
      r_first_valid <= 1'b1;
    end else if (i_first_ready) begin
      r_first_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_second_data  <= '0;
      r_second_valid <= 1'b0;
    end else if (w_load_second) begin
      r_second_data  <= {i_in_data, r_asm};
      r_second_valid <= 1'b1;
    end else if (i_second_ready) begin
      r_second_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_third_data  <= '0;
      r_third_valid <= 1'b0;
    end else if (w_load_third) begin
      r_third_data  <= {i_in_data, r_asm};
      r_third_valid <= 1'b1;
    end else if (i_third_ready) begin
      r_third_valid <= 1'b0;
    end
  end

  assign o_in_ready     = w_in_ready && i_reset;
  assign o_first_data   = r_first_data;
  assign o_first_valid  = r_first_valid;
  assign o_second_data  = r_second_data;
  assign o_second_valid = r_second_valid;
  assign o_third_data   = r_third_data;
  assign o_third_valid  = r_third_valid;

endmodule
`default_nettype wire

// File: tb/tb_deconcatenator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_deconcatenator: self-checking bench for the frame deconcatenator.      |
// |                                                        Revision: 1.0     |
// +--------------------------------------------------------------------------+
module tb_deconcatenator;

  localparam int F     = 144;
  localparam int S     = 1;
  localparam int T     = 11;
  localparam int FRAME = F + 12 * (S + T);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  first_data;
  logic        first_valid;
  logic        first_ready = 1'b1;
  logic [95:0] second_data;
  logic        second_valid;
  logic        second_ready = 1'b1;
  logic [95:0] third_data;
  logic        third_valid;
  logic        third_ready = 1'b1;

  always #5 clk = ~clk;

  deconcatenator #(.FIRST_BYTES(F), .SECOND_WORDS(S), .THIRD_WORDS(T)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .o_first_data(first_data), .o_first_valid(first_valid), .i_first_ready(first_ready),
    .o_second_data(second_data), .o_second_valid(second_valid), .i_second_ready(second_ready),
    .o_third_data(third_data), .o_third_valid(third_valid), .i_third_ready(third_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic finish_now();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Reference model: ideal split of the accepted byte stream by frame position
  logic [7:0]  q_first[$];
  logic [95:0] q_second[$];
  logic [95:0] q_third[$];
  int          m_pos = 0;
  logic [95:0] m_word = '0;

  task automatic model_accept(input logic [7:0] b);
    int k;
    if (m_pos < F) begin
      q_first.push_back(b);
    end else begin
      k = (m_pos - F) % 12;
      m_word[8*k +: 8] = b;
      if (k == 11) begin
        if (m_pos < F + 12 * S) q_second.push_back(m_word);
        else q_third.push_back(m_word);
      end
    end
    m_pos = (m_pos + 1) % FRAME;
  endtask

  task automatic model_flush();
    q_first.delete();
    q_second.delete();
    q_third.delete();
    m_pos = 0;
  endtask

  function automatic logic [95:0] wexp(input int start);
    logic [95:0] w;
    for (int k = 0; k < 12; k++) w[8*k +: 8] = 8'((start + k) & 255);
    return w;
  endfunction

  // Scoreboard and hold monitor, sampled on the falling edge
  int n_acc = 0, n_first = 0, n_second = 0, n_third = 0, n_valid_cycles = 0;
  logic [95:0] last_second = '0, first_third = '0, last_third = '0;
  bit p_f = 0, p_s = 0, p_t = 0;
  logic [7:0]  p_fd;
  logic [95:0] p_sd, p_td;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_f = 0; p_s = 0; p_t = 0;
    end else begin
      if (first_valid || second_valid || third_valid) n_valid_cycles++;
      if (in_valid && in_ready) begin
        model_accept(in_data);
        n_acc++;
      end
      if (p_f) begin check("first_hold_valid", 96'(first_valid), 96'd1); check("first_hold_data", 96'(first_data), 96'(p_fd)); end
      if (p_s) begin check("second_hold_valid", 96'(second_valid), 96'd1); check("second_hold_data", second_data, p_sd); end
      if (p_t) begin check("third_hold_valid", 96'(third_valid), 96'd1); check("third_hold_data", third_data, p_td); end
      p_f = first_valid && !first_ready;  p_fd = first_data;
      p_s = second_valid && !second_ready; p_sd = second_data;
      p_t = third_valid && !third_ready;  p_td = third_data;
      if (first_valid && first_ready) begin
        n_first++;
        if (q_first.size() == 0) check("first_unexpected", 96'(first_data), 96'hx);
        else check("first_data", 96'(first_data), 96'(q_first.pop_front()));
      end
      if (second_valid && second_ready) begin
        n_second++;
        last_second = second_data;
        if (q_second.size() == 0) check("second_unexpected", second_data, 96'hx);
        else check("second_data", second_data, q_second.pop_front());
      end
      if (third_valid && third_ready) begin
        if (n_third == 0) first_third = third_data;
        n_third++;
        last_third = third_data;
        if (q_third.size() == 0) check("third_unexpected", third_data, 96'hx);
        else check("third_data", third_data, q_third.pop_front());
      end
    end
  end

  // Ready drivers
  int pct_f = 100, pct_s = 100, pct_t = 100, vpct = 100;
  bit manual = 0;
  longint cyc = 0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (!manual) begin
      first_ready  = ($urandom_range(0, 99) < pct_f);
      second_ready = ($urandom_range(0, 99) < pct_s);
      third_ready  = ($urandom_range(0, 99) < pct_t);
    end
  end

  task automatic send(input logic [7:0] b);
    int guard;
    bit acc;
    while ($urandom_range(0, 99) >= vpct) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    guard    = 0;
    forever begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      guard++;
      if (guard > 5000) begin
        checks++; failures++;
        $display("FAIL send_timeout actual=stalled required=accepted");
        finish_now();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_flush();
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n_acc = 0; n_first = 0; n_second = 0; n_third = 0; n_valid_cycles = 0;
  endtask

  task automatic drain(input string tag);
    manual = 0; pct_f = 100; pct_s = 100; pct_t = 100;
    for (int i = 0; i < 200 && (q_first.size() + q_second.size() + q_third.size()) != 0; i++)
      @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_pending"}, 96'(q_first.size() + q_second.size() + q_third.size()), 96'd0);
  endtask

  typedef struct {
    int nbytes; int idle; int vp; int rp;
    int exp_f; int exp_s; int exp_t; int exp_cycles;
  } vec_t;
  vec_t vecs[4];

  initial begin
    #5_000_000;
    checks++; failures++;
    $display("FAIL watchdog actual=running required=finished");
    finish_now();
  end

  initial begin
    longint t0;
    vecs[0] = '{0,   1000, 100, 100, 0,   0, 0,  -1};
    vecs[1] = '{288, 0,    100, 100, 144, 1, 11, 288};
    vecs[2] = '{864, 0,    100, 100, 432, 3, 33, 864};
    vecs[3] = '{576, 0,    50,  50,  288, 2, 22, -1};

    #2;
    check("rst_in_ready", 96'(in_ready), 96'd0);
    check("rst_valids", {93'd0, first_valid, second_valid, third_valid}, 96'd0);
    check("rst_first_data", 96'(first_data), 96'd0);
    check("rst_second_data", second_data, 96'd0);
    check("rst_third_data", third_data, 96'd0);

    foreach (vecs[i]) begin
      do_reset();
      pct_f = vecs[i].rp; pct_s = vecs[i].rp; pct_t = vecs[i].rp;
      vpct = vecs[i].vp;
      repeat (vecs[i].idle) @(posedge clk);
      #0;
      t0 = cyc;
      for (int j = 0; j < vecs[i].nbytes; j++) send(8'(j & 255));
      if (vecs[i].exp_cycles >= 0)
        check($sformatf("v%0d_cycles", i), 96'(cyc - t0), 96'(vecs[i].exp_cycles));
      drain($sformatf("v%0d", i));
      check($sformatf("v%0d_accepted", i), 96'(n_acc), 96'(vecs[i].nbytes));
      check($sformatf("v%0d_first_count", i), 96'(n_first), 96'(vecs[i].exp_f));
      check($sformatf("v%0d_second_count", i), 96'(n_second), 96'(vecs[i].exp_s));
      check($sformatf("v%0d_third_count", i), 96'(n_third), 96'(vecs[i].exp_t));
      if (vecs[i].nbytes == 0)
        check("idle_valid_cycles", 96'(n_valid_cycles), 96'd0);
      if (vecs[i].nbytes == FRAME) begin
        check("single_second_word", last_second, wexp(144));
        check("single_third_word0", first_third, wexp(156));
        check("single_third_word10", last_third, wexp(276));
      end
    end
    vpct = 100;

    // Backpressure on segment 3 while word 0 is pending
    do_reset();
    manual = 1; first_ready = 1'b1; second_ready = 1'b1; third_ready = 1'b0;
    for (int j = 0; j < 179; j++) send(8'(j));
    in_data = 8'd179; in_valid = 1'b1;
    @(negedge clk);
    check("bp_in_ready_low", 96'(in_ready), 96'd0);
    check("bp_third_valid", 96'(third_valid), 96'd1);
    check("bp_third_word0", third_data, wexp(156));
    repeat (4) @(negedge clk);
    check("bp_still_blocked", 96'(in_ready), 96'd0);
    check("bp_word0_held", third_data, wexp(156));
    @(posedge clk); #1 third_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_high", 96'(in_ready), 96'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_word1_valid", 96'(third_valid), 96'd1);
    check("bp_word1_data", third_data, wexp(168));
    @(posedge clk); #1;
    for (int j = 180; j < FRAME; j++) send(8'(j & 255));
    drain("bp");
    check("bp_accepted", 96'(n_acc), 96'(FRAME));
    check("bp_third_count", 96'(n_third), 96'(T));

    // Asynchronous reset inside segment 2, then a clean frame
    do_reset();
    for (int j = 0; j < 150; j++) send(8'(j));
    #3;
    rst_n = 1'b0;
    model_flush();
    #1;
    check("mr_valids", {93'd0, first_valid, second_valid, third_valid}, 96'd0);
    check("mr_in_ready", 96'(in_ready), 96'd0);
    check("mr_second_data", second_data, 96'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_acc = 0; n_first = 0; n_second = 0; n_third = 0;
    for (int j = 0; j < FRAME; j++) send(8'(j & 255));
    drain("mr");
    check("mr_first_count", 96'(n_first), 96'(F));
    check("mr_second_count", 96'(n_second), 96'(S));
    check("mr_third_count", 96'(n_third), 96'(T));
    check("mr_second_word", last_second, wexp(144));

    finish_now();
  end

endmodule
`default_nettype wire

// File: doc/deconcatenator.md
Name: deconcatenator

Overview:
- Splits one 8-bit byte stream into three downstream streams, one fixed-length frame at a time.
- Segment 1 passes through as bytes; segments 2 and 3 are packed into 96-bit (12-byte) words.
- It is the receive-side counterpart of the concatenator. It sits between the byte-serial link and the header/payload consumers.
- Frames repeat back-to-back with no delimiter; position in the frame is tracked by counters only.

Parameters:
- FIRST_BYTES, 144, bytes in segment 1; must be >= 1.
- SECOND_WORDS, 1, 96-bit words in segment 2; must be >= 1.
- THIRD_WORDS, 11, 96-bit words in segment 3; must be >= 1.
- Frame length is FIRST_BYTES + 12*(SECOND_WORDS+THIRD_WORDS). With the defaults this is 288 bytes.

Ports:
- i_clock  in  1  sole clock, rising edge.
- i_reset  in  1  reset, asynchronous assert, active-low (0 = reset), released synchronously by the integrator.
- i_in_data  in  8  input byte.
- i_in_valid  in  1  input byte valid.
- o_in_ready  out  1  input byte accepted when valid & ready.
- o_first_data  out  8  segment-1 byte.
- o_first_valid  out  1  segment-1 valid.
- i_first_ready  in  1  segment-1 ready.
- o_second_data  out  96  segment-2 word.
- o_second_valid  out  1  segment-2 valid.
- i_second_ready  in  1  segment-2 ready.
- o_third_data  out  96  segment-3 word.
- o_third_valid  out  1  segment-3 valid.
- i_third_ready  in  1  segment-3 ready.

Behaviour:
- Reset (i_reset=0, async):
  - state=FIRST; byte and word counters = 0; assembly register cleared.
  - All o_*_valid = 0 and all o_*_data = 0; o_in_ready = 0 while in reset.
  - Reset mid-frame discards any partial word and pending outputs. After release, the next accepted byte is frame byte 0.
- State machine FIRST -> SECOND -> THIRD -> FIRST:
  - Transitions occur only on acceptance of the last byte of the current segment.
  - SECOND ends after byte 12*SECOND_WORDS-1 of that segment; THIRD ends after byte 12*THIRD_WORDS-1.
- Handshake rules:
  - Valid/ready on all ports; a transfer happens on a rising edge with valid & ready high.
  - Once an output valid is asserted, its data and valid hold until taken.
  - o_in_ready is combinational from state, counters and the output-register occupancy of the current state's segment only.
- FIRST:
  - Each accepted byte loads o_first_data; o_first_valid rises the next cycle (latency 1).
  - o_in_ready = !o_first_valid | i_first_ready, giving full throughput with ready held high.
- SECOND / THIRD:
  - Bytes go into a 96-bit assembly register, little-endian lanes: segment byte k of a word goes to bits [8k+7:8k], so byte 0 is in [7:0].
  - Bytes 0..10 of a word are always accepted (o_in_ready=1).
  - Byte 11 is accepted only if the segment's output register is empty or being taken this cycle (!o_x_valid | i_x_ready).
  - On acceptance of byte 11 the full word moves to o_second_data/o_third_data, and valid rises the next cycle. Latency is 1 cycle after the 12th byte, and throughput is one word per 12 input cycles.
- Output registers are independent:
  - A pending first/second word does not stall later segments, or the next frame's first-segment bytes, unless that same register is still occupied when it is needed again.
- Counters:
  - Byte counter width is clog2(max(FIRST_BYTES,12)).
  - Word counter width is clog2(max(SECOND_WORDS,THIRD_WORDS)).
  - Both counters wrap to 0 on segment end.
- i_in_valid low stalls counters and assembly with no effect. Data on unaccepted cycles is ignored.
- Frame wrap: after the last third-segment byte, state=FIRST and counters are 0. The next byte is frame byte 0.

Test Plan:
- No input: i_in_valid=0 for 1000 cycles, all readies=1 -> zero valid outputs on any port.
- Single frame, all readies=1: input bytes 0..287 -> outputs as follows:
  - Segment 1 emits 144 bytes, 0..143 in order.
  - Segment 2 emits one word {155,...,145,144}, with 144 in [7:0].
  - Segment 3 emits 11 words. Word n holds bytes 156+12n..167+12n, LSB first.
  - Exactly 288 input transfers occur with no stall cycles.
- Back-to-back frames: input bytes (count & 0xFF) for 3 frames, 864 bytes -> three identical segment patterns with the expected wrap values, and the state returns to FIRST each 288 bytes.
- Backpressure: i_third_ready=0 while word 0 of segment 3 is pending ->
  - o_in_ready drops at byte 11 of word 1, and the data holds stable.
  - After raising ready, word 1 appears the cycle after its 12th byte is accepted, and no byte is lost or duplicated.
- Random i_in_valid (50%) and random readies (50%) on all ports -> per-port sequences match the ideal split exactly, and valid is never withdrawn without a transfer.
- Reset mid-frame: i_reset=0 at input byte 150, inside segment 2 -> all valids=0 immediately (async). After release, bytes 0..287 produce a clean frame with no stale partial word.
